serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around one full_adder cell. It accepts an operand pair

---
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop. The operands shift through
// LSB-first, one bit per clock, and the result is handed back over a valid/ready port.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last      = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // sum/cout are loaded only on the RUN->DONE edge, so they hold the last result until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum  <= {fa_s, sum_sh[WIDTH-1:1]};
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes a+b+cin into a queue, a monitor
// compares every cycle the DUT shows out_valid and pops on the handshake.

module tb_serial_adder;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic [WIDTH:0] exp_q[$];
  int tests = 0;
  int failures = 0;
  int issued = 0;
  int popped = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a held result must match the head of the queue every cycle it is presented
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("result", 32'({cout, sum}), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic randomizeInputs();
    in_valid = 1'($urandom);
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    cin      = 1'($urandom);
  endtask

  task automatic acceptOp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back((WIDTH+1)'(ta) + (WIDTH+1)'(tb) + (WIDTH+1)'(tcin));
    issued++;
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input bit garbage);
    int k = 0;
    while (!out_valid && k < WIDTH + 4) begin
      if (garbage) randomizeInputs();
      @(posedge clk); #1;
      k++;
    end
    checkOutput("latency", 32'(k), 32'(WIDTH));
    checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic releaseOp(input int stall, input bit garbage);
    for (int i = 0; i < stall; i++) begin
      if (garbage) randomizeInputs();
      @(posedge clk); #1;
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tcin, input int stall, input bit garbage);
    acceptOp(ta, tb, tcin);
    waitDone(garbage);
    releaseOp(stall, garbage);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    applyStimulus(8'h5A, 8'hA5, 1'b1, 0, 1'b0);
    applyStimulus(8'h12, 8'h34, 1'b0, 0, 1'b0);
    applyStimulus(8'hC3, 8'h7E, 1'b1, 5, 1'b0);
    applyStimulus(8'h81, 8'h80, 1'b0, 3, 1'b1);

    // Completion and a new request on the same edge: the new pair waits one edge
    acceptOp(8'h20, 8'h22, 1'b0);
    waitDone(1'b0);
    a = 8'h99; b = 8'h77; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("simul_in_ready", 32'(in_ready), 32'd1);
    checkOutput("simul_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(9'h099 + 9'h077 + 9'h001);
    issued++;
    in_valid = 1'b0;
    checkOutput("simul_accepted", 32'(in_ready), 32'd0);
    waitDone(1'b0);
    releaseOp(1, 1'b0);

    // Asynchronous reset in the middle of a RUN
    acceptOp(8'hAA, 8'h55, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    issued--;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
    applyStimulus(8'h0F, 8'h01, 1'b0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("result_count", 32'(popped), 32'(issued));
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
